note_lane_engine: RTL and testbench

//  Parametrised falling-note engine for the Guitar Hero VGA path: LANES lanes with SLOTS note slots each.
//  - Accepts note-spawn requests from the song sequencer.
//  - Advances every live note by SPEED rows per frame tick.
//  - Judges player strums against a hit window.
//  - Retires notes that leave the screen.
//  - Gives the pixel mux a registered per-lane "pixel inside a note" vector.

---
 rtl/note_lane_engine.sv | 206 ++++++++++++++++++++
 tb/tb_note_lane_engine.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_lane_engine.sv
`default_nettype none
// ============================================================================
// Module   : note_lane_engine
// Brief    : Falling-note slot engine: spawn, per-frame advance, strum judge,
//            off-screen retire and registered per-lane pixel coverage.
// Revision : 1.0 - initial release
// ============================================================================
module note_lane_engine #(
    parameter int LANES      = 4,
    parameter int SLOTS      = 4,
    parameter int Y_W        = 11,
    parameter int SCREEN_H   = 480,
    parameter int NOTE_H     = 50,
    parameter int NOTE_W     = 50,
    parameter int LANE_X0    = 170,
    parameter int LANE_PITCH = 100,
    parameter int SPEED      = 1,
    parameter int HIT_LO     = 380,
    parameter int HIT_HI     = 430
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             spawn_valid,
    input  logic [LANES-1:0] spawn_mask,
    output logic             spawn_ready,
    input  logic [LANES-1:0] strum,
    input  logic [9:0]       x,
    input  logic [8:0]       y,
    output logic [LANES-1:0] pix_on,
    output logic [LANES-1:0] hit_pulse,
    output logic [LANES-1:0] miss_pulse,
    output logic [15:0]      hit_count,
    output logic [7:0]       live_count
);

    localparam int c_YE = Y_W + 1;
    localparam logic signed [Y_W-1:0]  c_SPAWN_Y  = Y_W'(-NOTE_H);
    localparam logic signed [c_YE-1:0] c_SCREEN_H = c_YE'(SCREEN_H);
    localparam logic signed [c_YE-1:0] c_HIT_LO   = c_YE'(HIT_LO);
    localparam logic signed [c_YE-1:0] c_HIT_HI   = c_YE'(HIT_HI);
    localparam logic signed [c_YE-1:0] c_NOTE_H   = c_YE'(NOTE_H);
    localparam logic signed [c_YE-1:0] c_SPEED    = c_YE'(SPEED);

    logic [LANES-1:0][SLOTS-1:0] r_valid;
    logic signed [Y_W-1:0]       r_y [LANES][SLOTS];
    logic [LANES-1:0]            r_pix_on;
    logic [LANES-1:0]            r_hit_pulse;
    logic [LANES-1:0]            r_miss_pulse;
    logic [15:0]                 r_hit_count;
    logic [7:0]                  r_live_count;

    logic [LANES-1:0][SLOTS-1:0] w_valid_nxt;
    logic signed [Y_W-1:0]       w_y_nxt [LANES][SLOTS];
    logic [LANES-1:0][SLOTS-1:0] w_hit_sel;
    logic [LANES-1:0][SLOTS-1:0] w_spawn_sel;
    logic [LANES-1:0]            w_lane_free;
    logic [LANES-1:0]            w_found;
    logic [LANES-1:0]            w_taken;
    logic [LANES-1:0]            w_hit;
    logic [LANES-1:0]            w_miss;
    logic [LANES-1:0]            w_pix;
    logic signed [Y_W-1:0]       w_best_y [LANES];
    logic signed [c_YE-1:0]      w_adv;
    logic signed [c_YE-1:0]      w_scan_y;
    logic signed [c_YE-1:0]      w_top;
    logic signed [c_YE-1:0]      w_bot;
    logic [15:0]                 w_scan_x;
    logic [15:0]                 w_x0;
    logic                        w_accept;
    logic [3:0]                  w_hit_n;
    logic [16:0]                 w_hit_sum;
    logic [7:0]                  w_live_n;

    always_comb begin
        w_lane_free = '0;
        w_found     = '0;
        w_taken     = '0;
        w_hit       = '0;
        w_miss      = '0;
        w_pix       = '0;
        w_hit_sel   = '0;
        w_spawn_sel = '0;
        w_valid_nxt = r_valid;
        w_adv       = '0;
        w_top       = '0;
        w_bot       = '0;
        w_x0        = '0;
        w_hit_n     = '0;
        w_live_n    = '0;
        w_scan_x    = 16'(x);
        w_scan_y    = c_YE'({1'b0, y});
        for (int l = 0; l < LANES; l++) begin
            w_best_y[l] = '0;
            for (int s = 0; s < SLOTS; s++) begin
                w_y_nxt[l][s] = r_y[l][s];
            end
        end

        for (int l = 0; l < LANES; l++) begin
            w_lane_free[l] = ~&r_valid[l];
        end
        spawn_ready = &w_lane_free;
        w_accept    = spawn_valid & spawn_ready;

        for (int l = 0; l < LANES; l++) begin
            // Strict '>' keeps the lowest slot index when two candidates tie on y.
            for (int s = 0; s < SLOTS; s++) begin
                if (r_valid[l][s] && (c_YE'(r_y[l][s]) >= c_HIT_LO) &&
                    (c_YE'(r_y[l][s]) <= c_HIT_HI) &&
                    (!w_found[l] || (r_y[l][s] > w_best_y[l]))) begin
                    w_found[l]     = 1'b1;
                    w_best_y[l]    = r_y[l][s];
                    w_hit_sel[l]   = '0;
                    w_hit_sel[l][s] = 1'b1;
                end
            end
            if (!strum[l]) begin
                w_hit_sel[l] = '0;
            end
            w_hit[l]  = strum[l] & w_found[l];
            w_miss[l] = strum[l] & ~w_found[l];

            for (int s = 0; s < SLOTS; s++) begin
                if (!r_valid[l][s] && !w_taken[l]) begin
                    w_taken[l]        = 1'b1;
                    w_spawn_sel[l][s] = w_accept & spawn_mask[l];
                end
            end

            for (int s = 0; s < SLOTS; s++) begin
                w_adv = c_YE'(r_y[l][s]) + c_SPEED;
                if (r_valid[l][s]) begin
                    if (w_hit_sel[l][s]) begin
                        w_valid_nxt[l][s] = 1'b0;
                    end else if (frame_tick) begin
                        if (w_adv >= c_SCREEN_H) begin
                            w_valid_nxt[l][s] = 1'b0;
                            w_miss[l]         = 1'b1;
                        end else begin
                            w_y_nxt[l][s] = w_adv[Y_W-1:0];
                        end
                    end
                end else if (w_spawn_sel[l][s]) begin
                    w_valid_nxt[l][s] = 1'b1;
                    w_y_nxt[l][s]     = c_SPAWN_Y;
                end
            end

            // Pixel coverage uses the slot state seen at the start of the cycle.
            w_x0 = 16'(LANE_X0 + l * LANE_PITCH);
            for (int s = 0; s < SLOTS; s++) begin
                w_top = c_YE'(r_y[l][s]);
                w_bot = w_top + c_NOTE_H;
                if (r_valid[l][s] && (w_scan_x >= w_x0) && (w_scan_x < w_x0 + 16'(NOTE_W)) &&
                    (w_scan_y >= w_top) && (w_scan_y < w_bot)) begin
                    w_pix[l] = 1'b1;
                end
            end
        end

        for (int l = 0; l < LANES; l++) begin
            w_hit_n = w_hit_n + 4'(w_hit[l]);
            for (int s = 0; s < SLOTS; s++) begin
                w_live_n = w_live_n + 8'(w_valid_nxt[l][s]);
            end
        end
        w_hit_sum = 17'(r_hit_count) + 17'(w_hit_n);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid      <= '0;
            r_pix_on     <= '0;
            r_hit_pulse  <= '0;
            r_miss_pulse <= '0;
            r_hit_count  <= '0;
            r_live_count <= '0;
            for (int l = 0; l < LANES; l++) begin
                for (int s = 0; s < SLOTS; s++) begin
                    r_y[l][s] <= '0;
                end
            end
        end else begin
            r_valid      <= w_valid_nxt;
            r_pix_on     <= w_pix;
            r_hit_pulse  <= w_hit;
            r_miss_pulse <= w_miss;
            r_hit_count  <= w_hit_sum[16] ? 16'hFFFF : w_hit_sum[15:0];
            r_live_count <= w_live_n;
            for (int l = 0; l < LANES; l++) begin
                for (int s = 0; s < SLOTS; s++) begin
                    r_y[l][s] <= w_y_nxt[l][s];
                end
            end
        end
    end

    assign pix_on     = r_pix_on;
    assign hit_pulse  = r_hit_pulse;
    assign miss_pulse = r_miss_pulse;
    assign hit_count  = r_hit_count;
    assign live_count = r_live_count;

endmodule
`default_nettype wire

// File: tb/tb_note_lane_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_lane_engine
// Brief    : Self-checking bench for note_lane_engine against a note-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_note_lane_engine;

    localparam int LANES      = 4;
    localparam int SLOTS      = 4;
    localparam int Y_W        = 11;
    localparam int SCREEN_H   = 480;
    localparam int NOTE_H     = 50;
    localparam int NOTE_W     = 50;
    localparam int LANE_X0    = 170;
    localparam int LANE_PITCH = 100;
    localparam int SPEED      = 1;
    localparam int HIT_LO     = 380;
    localparam int HIT_HI     = 430;

    typedef struct {
        int lane;
        int y;
    } note_t;

    typedef struct {
        logic [9:0]       px;
        logic [8:0]       py;
        logic [LANES-1:0] pix;
    } pix_vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             frame_tick;
    logic             spawn_valid;
    logic [LANES-1:0] spawn_mask;
    logic             spawn_ready;
    logic [LANES-1:0] strum;
    logic [9:0]       x;
    logic [8:0]       y;
    logic [LANES-1:0] pix_on;
    logic [LANES-1:0] hit_pulse;
    logic [LANES-1:0] miss_pulse;
    logic [15:0]      hit_count;
    logic [7:0]       live_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: an unordered list of live notes; slot indices are not observable.
    note_t            notes[$];
    logic [LANES-1:0] e_pix;
    logic [LANES-1:0] e_hit;
    logic [LANES-1:0] e_miss;
    int               e_hc;
    int               e_live;

    note_lane_engine #(
        .LANES(LANES), .SLOTS(SLOTS), .Y_W(Y_W), .SCREEN_H(SCREEN_H),
        .NOTE_H(NOTE_H), .NOTE_W(NOTE_W), .LANE_X0(LANE_X0),
        .LANE_PITCH(LANE_PITCH), .SPEED(SPEED), .HIT_LO(HIT_LO), .HIT_HI(HIT_HI)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .spawn_valid(spawn_valid), .spawn_mask(spawn_mask), .spawn_ready(spawn_ready),
        .strum(strum), .x(x), .y(y), .pix_on(pix_on), .hit_pulse(hit_pulse),
        .miss_pulse(miss_pulse), .hit_count(hit_count), .live_count(live_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        int cnt [LANES];
        for (int l = 0; l < LANES; l++) cnt[l] = 0;
        for (int i = 0; i < notes.size(); i++) cnt[notes[i].lane]++;
        for (int l = 0; l < LANES; l++) if (cnt[l] >= SLOTS) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_clear();
        notes.delete();
        e_pix  = '0;
        e_hit  = '0;
        e_miss = '0;
        e_hc   = 0;
        e_live = 0;
    endfunction

    function automatic void model_step();
        note_t nxt[$];
        note_t t;
        int    best [LANES];
        bit    rdy;
        int    ny;
        int    x0;
        rdy    = model_ready();
        e_pix  = '0;
        e_hit  = '0;
        e_miss = '0;
        for (int l = 0; l < LANES; l++) best[l] = -1;
        for (int i = 0; i < notes.size(); i++) begin
            t  = notes[i];
            x0 = LANE_X0 + t.lane * LANE_PITCH;
            if (int'(x) >= x0 && int'(x) < x0 + NOTE_W && int'(y) >= t.y && int'(y) < t.y + NOTE_H)
                e_pix[t.lane] = 1'b1;
            if (t.y >= HIT_LO && t.y <= HIT_HI &&
                (best[t.lane] < 0 || t.y > notes[best[t.lane]].y))
                best[t.lane] = i;
        end
        for (int l = 0; l < LANES; l++) begin
            if (strum[l]) begin
                if (best[l] >= 0) e_hit[l] = 1'b1;
                else              e_miss[l] = 1'b1;
            end
        end
        for (int i = 0; i < notes.size(); i++) begin
            t = notes[i];
            if (!(strum[t.lane] && best[t.lane] == i)) begin
                ny = t.y + (frame_tick ? SPEED : 0);
                if (ny >= SCREEN_H) begin
                    e_miss[t.lane] = 1'b1;
                end else begin
                    t.y = ny;
                    nxt.push_back(t);
                end
            end
        end
        if (spawn_valid && rdy) begin
            for (int l = 0; l < LANES; l++) begin
                if (spawn_mask[l]) begin
                    t.lane = l;
                    t.y    = -NOTE_H;
                    nxt.push_back(t);
                end
            end
        end
        e_hc = e_hc + $countones(e_hit);
        if (e_hc > 65535) e_hc = 65535;
        notes  = nxt;
        e_live = notes.size();
    endfunction

    task automatic cycle();
        chk("spawn_ready", 32'(spawn_ready), 32'(model_ready()));
        model_step();
        @(posedge clk);
        #1;
        chk("pix_on", 32'(pix_on), 32'(e_pix));
        chk("hit_pulse", 32'(hit_pulse), 32'(e_hit));
        chk("miss_pulse", 32'(miss_pulse), 32'(e_miss));
        chk("hit_count", 32'(hit_count), 32'(e_hc));
        chk("live_count", 32'(live_count), 32'(e_live));
        frame_tick  = 1'b0;
        spawn_valid = 1'b0;
        spawn_mask  = '0;
        strum       = '0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            cycle();
        end
    endtask

    task automatic spawn(input logic [LANES-1:0] m, input logic tk);
        spawn_valid = 1'b1;
        spawn_mask  = m;
        frame_tick  = tk;
        cycle();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_ready", 32'(spawn_ready), 32'd1);
        chk("rst_live", 32'(live_count), 32'd0);
    endtask

    initial begin
        pix_vec_t         tbl [10];
        logic [LANES-1:0] prev;

        tbl[0] = '{10'd175, 9'd400, 4'b0001};
        tbl[1] = '{10'd375, 9'd400, 4'b0100};
        tbl[2] = '{10'd169, 9'd400, 4'b0000};
        tbl[3] = '{10'd170, 9'd380, 4'b0001};
        tbl[4] = '{10'd219, 9'd429, 4'b0001};
        tbl[5] = '{10'd220, 9'd400, 4'b0000};
        tbl[6] = '{10'd419, 9'd429, 4'b0100};
        tbl[7] = '{10'd375, 9'd430, 4'b0000};
        tbl[8] = '{10'd275, 9'd400, 4'b0000};
        tbl[9] = '{10'd375, 9'd379, 4'b0000};

        reset       = 1'b0;
        frame_tick  = 1'b0;
        spawn_valid = 1'b0;
        spawn_mask  = '0;
        strum       = '0;
        x           = '0;
        y           = '0;
        model_clear();
        #2;
        chk("init_pix", 32'(pix_on), 32'd0);
        chk("init_hits", 32'(hit_count), 32'd0);
        do_reset();

        // T2: spawn lanes 0 and 2, fall to y=380, probe pixel coverage
        spawn(4'b0101, 1'b0);
        tick_n(430);
        chk("t2_live", 32'(live_count), 32'd2);
        prev = e_pix;
        for (int i = 0; i < 10; i++) begin
            x = tbl[i].px;
            y = tbl[i].py;
            #1 chk("pix_latency", 32'(pix_on), 32'(prev));
            cycle();
            chk("pix_table", 32'(pix_on), 32'(tbl[i].pix));
            prev = tbl[i].pix;
        end

        // T3: hit window lower edge
        do_reset();
        spawn(4'b0010, 1'b0);
        tick_n(429);
        strum = 4'b0010;
        cycle();
        chk("t3_early_miss", 32'(miss_pulse), 32'b0010);
        chk("t3_early_nohit", 32'(hit_pulse), 32'd0);
        chk("t3_survive", 32'(live_count), 32'd1);
        tick_n(1);
        strum = 4'b0010;
        cycle();
        chk("t3_hit", 32'(hit_pulse), 32'b0010);
        chk("t3_hit_count", 32'(hit_count), 32'd1);
        chk("t3_freed", 32'(live_count), 32'd0);

        // T5: off-screen retire at y=480
        do_reset();
        spawn(4'b1000, 1'b0);
        tick_n(529);
        chk("t5_at_479", 32'(live_count), 32'd1);
        tick_n(1);
        chk("t5_retire_miss", 32'(miss_pulse), 32'b1000);
        chk("t5_retire_live", 32'(live_count), 32'd0);
        cycle();
        chk("t5_miss_one_cycle", 32'(miss_pulse), 32'd0);

        // T4: fill every slot, refuse a fifth row, free one per lane
        do_reset();
        for (int i = 0; i < 4; i++) spawn(4'b1111, 1'b1);
        chk("t4_full_ready", 32'(spawn_ready), 32'd0);
        chk("t4_full_live", 32'(live_count), 32'd16);
        spawn(4'b1111, 1'b0);
        chk("t4_fifth_live", 32'(live_count), 32'd16);
        tick_n(427);
        strum = 4'b0001;
        cycle();
        chk("t4_lane0_hit", 32'(hit_pulse), 32'b0001);
        chk("t4_one_lane_free", 32'(spawn_ready), 32'd0);
        tick_n(99);
        chk("t4_before_retire", 32'(spawn_ready), 32'd0);
        tick_n(1);
        chk("t4_retire_miss", 32'(miss_pulse), 32'b1110);
        chk("t4_ready_again", 32'(spawn_ready), 32'd1);
        chk("t4_live_12", 32'(live_count), 32'd12);

        // T6: strum + tick + spawn together in lane 3 (notes at 400 and 390)
        do_reset();
        spawn(4'b1000, 1'b0);
        tick_n(10);
        spawn(4'b1000, 1'b0);
        tick_n(440);
        chk("t6_pre_live", 32'(live_count), 32'd2);
        strum       = 4'b1000;
        frame_tick  = 1'b1;
        spawn_valid = 1'b1;
        spawn_mask  = 4'b1000;
        cycle();
        chk("t6_hit", 32'(hit_pulse), 32'b1000);
        chk("t6_hit_count", 32'(hit_count), 32'd1);
        chk("t6_live_same", 32'(live_count), 32'd2);
        x = 10'd475;
        y = 9'd390; cycle(); chk("t6_y390", 32'(pix_on), 32'd0);
        y = 9'd391; cycle(); chk("t6_y391", 32'(pix_on), 32'b1000);
        y = 9'd440; cycle(); chk("t6_y440", 32'(pix_on), 32'b1000);
        y = 9'd441; cycle(); chk("t6_y441", 32'(pix_on), 32'd0);
        y = 9'd0;   cycle(); chk("t6_new_hidden", 32'(pix_on), 32'd0);
        tick_n(1);
        cycle();
        chk("t6_new_row0", 32'(pix_on), 32'b1000);

        // T1: asynchronous reset mid-cycle with live notes and nonzero outputs
        spawn(4'b0111, 1'b0);
        tick_n(60);
        x     = 10'd175;
        y     = 9'd20;
        strum = 4'b0010;
        cycle();
        chk("t1_pre_pix", 32'(pix_on), 32'b0001);
        chk("t1_pre_miss", 32'(miss_pulse), 32'b0010);
        chk("t1_pre_live", 32'(live_count), 32'd5);
        #2 reset = 1'b0;
        model_clear();
        #1;
        chk("t1_rst_pix", 32'(pix_on), 32'd0);
        chk("t1_rst_miss", 32'(miss_pulse), 32'd0);
        chk("t1_rst_hits", 32'(hit_count), 32'd0);
        chk("t1_rst_live", 32'(live_count), 32'd0);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("t1_rel_ready", 32'(spawn_ready), 32'd1);
        chk("t1_rel_live", 32'(live_count), 32'd0);

        // Randomised traffic against the note-list model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            frame_tick  = ($urandom_range(0, 3) != 0);
            spawn_valid = ($urandom_range(0, 15) == 0);
            spawn_mask  = LANES'($urandom);
            for (int l = 0; l < LANES; l++) strum[l] = ($urandom_range(0, 7) == 0);
            x = 10'($urandom_range(160, 530));
            y = 9'($urandom_range(0, 479));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
